// File: rtl/nor_gate_sweep_checker.sv
// nor_gate_sweep_checker
//   Exhaustive sweep engine for N-input gate experiments. It walks an N-bit
//   stimulus vector through all 2^N values and holds each one for HOLD
//   cycles. On the last cycle of each vector it compares two DUT outputs
//   (direct and De Morgan implementations) against a reference gate
//   function. The reference function is latched when the sweep starts.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   start           : one-cycle pulse; begins a sweep from IDLE or DONE
//   mode[1:0]       : reference function latched at start (00 NOR, 01 OR,
//                     10 NAND, 11 AND)
//   dut_d, dut_e    : DUT outputs (direct / De Morgan implementation)
//   vec[N-1:0]      : stimulus to the DUT inputs; bit 0 toggles fastest
//   expected        : reference function of vec under the latched mode
//   busy, done      : sweep running / sweep finished (done is held)
//   mismatch_cnt    : number of vectors where either DUT output was wrong
//   d_fail, e_fail  : sticky per-output fail flags
//   first_err_vec   : vector of the first mismatch (valid when cnt != 0)
//   dbg_state[1:0]  : FSM state for debug (0 IDLE, 1 DRIVE, 2 DONE)
//
// Control protocol: start has no ready/ack. It is sampled on every rising
// clock edge and is accepted only in IDLE or DONE. In DRIVE it is silently
// dropped. This includes the edge on which the FSM moves into DONE.
module nor_gate_sweep_checker #(
  parameter int N    = 3,
  parameter int HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic         dut_d,
  input  logic         dut_e,
  output logic [N-1:0] vec,
  output logic         expected,
  output logic         busy,
  output logic         done,
  output logic [N:0]   mismatch_cnt,
  output logic         d_fail,
  output logic         e_fail,
  output logic [N-1:0] first_err_vec,
  output logic [1:0]   dbg_state
);

  // A counter at least one bit wide, so that HOLD=1 still elaborates.
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [N-1:0]  VEC_LAST  = '1;
  localparam logic [N-1:0]  VEC_ONE   = N'(1);
  localparam logic [N:0]    CNT_ONE   = (N+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  vec_q, vec_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    mode_q, mode_d;
  logic [N:0]    cnt_q, cnt_d;
  logic          d_fail_q, d_fail_d;
  logic          e_fail_q, e_fail_d;
  logic [N-1:0]  first_q, first_d;
  logic          d_miss, e_miss;

  // Reference gate for the current vector under the latched mode.
  always_comb begin
    case (mode_q)
      2'b00:   expected = ~|vec_q;
      2'b01:   expected =  |vec_q;
      2'b10:   expected = ~&vec_q;
      default: expected =  &vec_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    hold_d   = hold_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    d_fail_d = d_fail_q;
    e_fail_d = e_fail_q;
    first_d  = first_q;
    d_miss   = 1'b0;
    e_miss   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_DRIVE;
          vec_d    = '0;
          hold_d   = '0;
          mode_d   = mode;
          cnt_d    = '0;
          d_fail_d = 1'b0;
          e_fail_d = 1'b0;
          first_d  = '0;
        end
      end
      S_DRIVE: begin
        if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HOLD_ONE;
        end else begin
          // Sample cycle. The DUT has had HOLD-1 cycles to settle.
          d_miss = (dut_d != expected);
          e_miss = (dut_e != expected);
          // Count once per vector, even when both outputs are wrong.
          if (d_miss || e_miss) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == '0) first_d = vec_q;
          end
          if (d_miss) d_fail_d = 1'b1;
          if (e_miss) e_fail_d = 1'b1;
          if (vec_q != VEC_LAST) begin
            vec_d  = vec_q + VEC_ONE;
            hold_d = '0;
          end else begin
            // The last vector stays on vec so the board LEDs show it.
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      hold_q   <= '0;
      mode_q   <= 2'b00;
      cnt_q    <= '0;
      d_fail_q <= 1'b0;
      e_fail_q <= 1'b0;
      first_q  <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      hold_q   <= hold_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      d_fail_q <= d_fail_d;
      e_fail_q <= e_fail_d;
      first_q  <= first_d;
    end
  end

  assign vec           = vec_q;
  assign busy          = (state_q == S_DRIVE);
  assign done          = (state_q == S_DONE);
  assign mismatch_cnt  = cnt_q;
  assign d_fail        = d_fail_q;
  assign e_fail        = e_fail_q;
  assign first_err_vec = first_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_nor_gate_sweep_checker.sv
// Testbench for nor_gate_sweep_checker.
//   u_dut : N=3, HOLD=4. A bench-side gate with per-vector flip masks
//           drives it, and a time-based sweep model checks it on every
//           cycle.
//   u_dut2: N=4, HOLD=1. A bench-side AND gate drives it, and it is
//           checked against literal per-cycle expectations.
module tb_nor_gate_sweep_checker;
  localparam int N     = 3;
  localparam int HOLD  = 4;
  localparam int NV    = 1 << N;
  localparam int N2    = 4;
  localparam int HOLD2 = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT 1 ----------------
  logic         start = 1'b0;
  logic [1:0]   mode  = 2'b00;
  logic         dut_d, dut_e;
  logic [N-1:0] vec;
  logic         expected, busy, done;
  logic [N:0]   mismatch_cnt;
  logic         d_fail, e_fail;
  logic [N-1:0] first_err_vec;
  logic [1:0]   dbg_state;

  // Bench-side gate: function gate_kind, per-vector flips, and optional stuck-0 on e.
  logic [1:0]    gate_kind = 2'b00;
  logic          e_force0  = 1'b0;
  logic [NV-1:0] d_flip    = '0;
  logic [NV-1:0] e_flip    = '0;

  nor_gate_sweep_checker #(.N(N), .HOLD(HOLD)) u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .dut_d(dut_d), .dut_e(dut_e), .vec(vec), .expected(expected),
    .busy(busy), .done(done), .mismatch_cnt(mismatch_cnt),
    .d_fail(d_fail), .e_fail(e_fail), .first_err_vec(first_err_vec),
    .dbg_state(dbg_state)
  );

  // ---------------- DUT 2 ----------------
  logic          start2 = 1'b0;
  logic [1:0]    mode2  = 2'b11;
  logic          dut2_d, dut2_e;
  logic [N2-1:0] vec2;
  logic          expected2, busy2, done2;
  logic [N2:0]   cnt2;
  logic          d_fail2, e_fail2;
  logic [N2-1:0] first2;
  logic [1:0]    dbg_state2;

  assign dut2_d = &vec2;
  assign dut2_e = &vec2;

  nor_gate_sweep_checker #(.N(N2), .HOLD(HOLD2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode2),
    .dut_d(dut2_d), .dut_e(dut2_e), .vec(vec2), .expected(expected2),
    .busy(busy2), .done(done2), .mismatch_cnt(cnt2),
    .d_fail(d_fail2), .e_fail(e_fail2), .first_err_vec(first2),
    .dbg_state(dbg_state2)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Gate function by truth: 0 NOR, 1 OR, 2 NAND, 3 AND over a vector value.
  function automatic logic gate_fn(input logic [1:0] m, input int v, input int nv);
    case (m)
      2'd0:    return (v == 0);
      2'd1:    return (v != 0);
      2'd2:    return (v != nv - 1);
      default: return (v == nv - 1);
    endcase
  endfunction

  always_comb begin
    dut_d = gate_fn(gate_kind, int'(vec), NV) ^ d_flip[vec];
    dut_e = e_force0 ? 1'b0 : (gate_fn(gate_kind, int'(vec), NV) ^ e_flip[vec]);
  end

  // ---------------- reference model ----------------
  // Sweep timeline: m_t counts the edges since start was accepted. The
  // current vector is m_t/HOLD. A vector is judged on the edge where m_t
  // reaches a multiple of HOLD.
  int         m_t;
  bit         m_busy, m_done;
  logic [1:0] m_mode;
  int         m_cnt, m_first;
  bit         m_df, m_ef;

  always @(posedge clk or posedge rst) begin : model_blk
    int   v;
    logic ex, dd, ee;
    if (rst) begin
      m_t = 0; m_busy = 0; m_done = 0; m_mode = 2'b00;
      m_cnt = 0; m_first = 0; m_df = 0; m_ef = 0;
    end else if (m_busy) begin
      m_t++;
      if (m_t % HOLD == 0) begin
        v  = (m_t - 1) / HOLD;
        ex = gate_fn(m_mode, v, NV);
        dd = gate_fn(gate_kind, v, NV) ^ d_flip[v];
        ee = e_force0 ? 1'b0 : (gate_fn(gate_kind, v, NV) ^ e_flip[v]);
        if (dd !== ex || ee !== ex) begin
          if (m_cnt == 0) m_first = v;
          m_cnt++;
        end
        if (dd !== ex) m_df = 1;
        if (ee !== ex) m_ef = 1;
        if (v == NV - 1) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end else if (start) begin
      m_busy = 1; m_done = 0; m_t = 0; m_mode = mode;
      m_cnt = 0; m_first = 0; m_df = 0; m_ef = 0;
    end
  end

  // Compare process: every falling edge, all outputs of u_dut against the model.
  always @(negedge clk) begin : compare_blk
    int mv;
    if (chk_en) begin
      mv = m_busy ? (m_t / HOLD) : (m_done ? NV - 1 : 0);
      chk("vec",           32'(vec),           32'(mv));
      chk("expected",      32'(expected),      32'(gate_fn(m_mode, mv, NV)));
      chk("busy",          32'(busy),          32'(m_busy));
      chk("done",          32'(done),          32'(m_done));
      chk("mismatch_cnt",  32'(mismatch_cnt),  32'(m_cnt));
      chk("d_fail",        32'(d_fail),        32'(m_df));
      chk("e_fail",        32'(e_fail),        32'(m_ef));
      chk("first_err_vec", 32'(first_err_vec), 32'(m_first));
    end
  end

  // ---------------- driver tasks ----------------
  // Raise start after an edge, then wait for done with a bound. The edge
  // count is measured from the edge after start was raised, so done is
  // seen on count 1 + NV*HOLD. pulse_at >= 0 adds one more start pulse
  // (with a different mode) while vec == pulse_at. noise adds random
  // start pulses and mode changes on every cycle.
  task automatic run_sweep(input logic [1:0] m, input int pulse_at, input bit noise,
                           output int edges);
    bit pulsed;
    pulsed = 0;
    @(posedge clk); #1;
    start = 1'b1; mode = m;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    while (!done && edges < 200) begin
      if (noise) begin
        start = ($urandom_range(0, 5) == 0);
        mode  = 2'($urandom_range(0, 3));
      end else if (!pulsed && pulse_at >= 0 && int'(vec) == pulse_at) begin
        start = 1'b1; mode = ~m; pulsed = 1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_vec(input int target);
    int guard;
    guard = 0;
    while (int'(vec) != target && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (int'(vec) != target) chk("wait_vec_timeout", 32'(vec), 32'(target));
  endtask

  // ---------------- main sequence ----------------
  initial begin : main_blk
    int edges;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Reset state.
    chk("rst_vec",      32'(vec),          32'd0);
    chk("rst_expected", 32'(expected),     32'd1);
    chk("rst_busy",     32'(busy),         32'd0);
    chk("rst_done",     32'(done),         32'd0);
    chk("rst_cnt",      32'(mismatch_cnt), 32'd0);

    // Correct NOR, mode NOR.
    gate_kind = 2'b00;
    run_sweep(2'b00, -1, 0, edges);
    chk("nor_done_latency", 32'(edges),        32'd33);
    chk("nor_cnt",          32'(mismatch_cnt), 32'd0);
    chk("nor_dfail",        32'(d_fail),       32'd0);
    chk("nor_efail",        32'(e_fail),       32'd0);
    chk("nor_final_vec",    32'(vec),          32'd7);

    // dut_e stuck at 0: only vector 0 (NOR=1) mismatches.
    e_force0 = 1'b1;
    run_sweep(2'b00, -1, 0, edges);
    e_force0 = 1'b0;
    chk("e0_cnt",   32'(mismatch_cnt),  32'd1);
    chk("e0_first", 32'(first_err_vec), 32'd0);
    chk("e0_efail", 32'(e_fail),        32'd1);
    chk("e0_dfail", 32'(d_fail),        32'd0);

    // NAND reference against a NOR DUT: vectors 1..6 mismatch.
    run_sweep(2'b10, -1, 0, edges);
    chk("nand_cnt",   32'(mismatch_cnt),  32'd6);
    chk("nand_first", 32'(first_err_vec), 32'd1);
    chk("nand_dfail", 32'(d_fail),        32'd1);
    chk("nand_efail", 32'(e_fail),        32'd1);

    // Back-to-back clean sweep clears the failing results.
    run_sweep(2'b00, -1, 0, edges);
    chk("b2b_cnt",   32'(mismatch_cnt),  32'd0);
    chk("b2b_dfail", 32'(d_fail),        32'd0);
    chk("b2b_efail", 32'(e_fail),        32'd0);
    chk("b2b_first", 32'(first_err_vec), 32'd0);

    // A start pulse while busy at vector 3 is ignored.
    run_sweep(2'b00, 3, 0, edges);
    chk("busy_start_latency", 32'(edges),        32'd33);
    chk("busy_start_cnt",     32'(mismatch_cnt), 32'd0);

    // A reset at vector 5 of a failing sweep aborts at once.
    @(posedge clk); #1;
    start = 1'b1; mode = 2'b10;
    @(posedge clk); #1;
    start = 1'b0;
    wait_vec(5);
    chk("pre_rst_cnt", 32'(mismatch_cnt), 32'd4);
    rst = 1'b1;
    #1;
    chk("arst_vec",   32'(vec),           32'd0);
    chk("arst_busy",  32'(busy),          32'd0);
    chk("arst_done",  32'(done),          32'd0);
    chk("arst_cnt",   32'(mismatch_cnt),  32'd0);
    chk("arst_dfail", 32'(d_fail),        32'd0);
    chk("arst_efail", 32'(e_fail),        32'd0);
    chk("arst_first", 32'(first_err_vec), 32'd0);
    chk("arst_exp",   32'(expected),      32'd1);
    @(posedge clk); #1 rst = 1'b0;
    run_sweep(2'b00, -1, 0, edges);
    chk("post_rst_latency", 32'(edges),        32'd33);
    chk("post_rst_cnt",     32'(mismatch_cnt), 32'd0);

    // Randomized sweeps: random gate, mode, flip masks and start noise.
    for (int r = 0; r < 8; r++) begin
      gate_kind = 2'($urandom_range(0, 3));
      d_flip    = NV'($urandom_range(0, NV - 1) * (r % 2) | ($urandom_range(0, 3) == 0 ? 0 : 0));
      d_flip    = NV'($urandom);
      e_flip    = NV'($urandom);
      if (r == 0) begin
        d_flip = '0;
        e_flip = '0;
      end
      run_sweep(2'($urandom_range(0, 3)), -1, 1, edges);
      chk("rand_latency", 32'(edges), 32'd33);
    end
    d_flip = '0;
    e_flip = '0;
    gate_kind = 2'b00;

    // N=4, HOLD=1, AND mode against an AND DUT.
    @(posedge clk); #1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("n4_vec",  32'(vec2),  32'(i));
      chk("n4_busy", 32'(busy2), 32'd1);
      chk("n4_done", 32'(done2), 32'd0);
      @(posedge clk); #1;
    end
    chk("n4_done_at_17", 32'(done2), 32'd1);
    chk("n4_busy_end",   32'(busy2), 32'd0);
    chk("n4_cnt",        32'(cnt2),  32'd0);
    chk("n4_vec_end",    32'(vec2),  32'd15);
    chk("n4_fails",      32'({d_fail2, e_fail2}), 32'd0);

    repeat (2) @(posedge clk);
    #1 chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Watchdog: a stuck sequence still ends with a summary line.
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nor_gate_sweep_checker.md
# nor_gate_sweep_checker

Self-checking exhaustive sweep engine for N-input gate experiments on the lab FPGA.
- Drives an N-bit input vector through all 2^N combinations and holds each vector for a programmable number of cycles.
- Samples two device-under-test outputs (direct implementation `dut_d`, De Morgan implementation `dut_e`) and compares both against a reference gate function selected at run time.
- Reports a mismatch count, sticky per-output fail flags and the first failing vector.
- Sits between the DUT gate module and the board LEDs/switches; replaces hand-written toggling stimulus with a repeatable hardware sweep.

## Interface
Parameters:
- `N`, 3, number of gate inputs (1..8)
- `HOLD`, 4, cycles each vector is held before sampling (>=1)

Ports:
- `clk` in 1: single clock
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: one-cycle pulse, begins a sweep from IDLE or DONE
- `mode` in 2: reference function, latched at start: 00 NOR, 01 OR, 10 NAND, 11 AND
- `dut_d` in 1: DUT output, direct implementation
- `dut_e` in 1: DUT output, alternate (De Morgan) implementation
- `vec` out N: stimulus to DUT inputs; bit 0 toggles fastest
- `expected` out 1: reference function of current `vec` under latched mode
- `busy` out 1: sweep in progress
- `done` out 1: sweep complete, held until next start or reset
- `mismatch_cnt` out N+1: number of vectors where either DUT output differed from `expected`
- `d_fail` out 1: sticky; `dut_d` mismatched at least once
- `e_fail` out 1: sticky; `e` mismatched at least once
- `first_err_vec` out N: vector of first mismatch; valid when `mismatch_cnt` != 0

## Operation
- FSM states: IDLE, DRIVE, DONE.
- Reset (async): state IDLE; `vec`=0, `busy`=0, `done`=0, `mismatch_cnt`=0, `d_fail`=0, `e_fail`=0, `first_err_vec`=0, latched mode=00. `expected` follows (NOR of 0 = 1).
- IDLE or DONE, `start`=1:
  - go to DRIVE; `vec`<=0, hold counter<=0, latch `mode`.
  - clear `mismatch_cnt`, fail flags, `first_err_vec` and `done`.
- DRIVE, hold counter < HOLD-1: increment hold counter; `vec` unchanged.
- DRIVE, hold counter == HOLD-1 (sample cycle):
  - compare `dut_d` and `dut_e` with `expected`.
  - if either differs: increment `mismatch_cnt` by 1 (per vector, not per output); set the corresponding fail flag(s).
  - if this is the first mismatch of the sweep: load `first_err_vec`<=`vec`.
  - if `vec` != 2^N-1: `vec`<=`vec`+1, hold counter<=0.
  - otherwise go to DONE with `vec` held at 2^N-1.
- `start` while in DRIVE is ignored.
- `mode` changes during DRIVE have no effect.
- `expected` is combinational from `vec` and latched mode: NOR = ~|vec, OR = |vec, NAND = ~&vec, AND = &vec.
- `mismatch_cnt` width N+1 holds the maximum value 2^N without wrap; no saturation logic is required.

## Timing
- `busy`=1 exactly while in DRIVE; `done`=1 exactly while in DONE. The two are never both high.
- Start pulse at edge k: DRIVE from edge k+1. Vector v occupies cycles k+1+v·HOLD … k+(v+1)·HOLD.
- DUT inputs are sampled on the last cycle of each vector, giving HOLD-1 cycles of settling.
- `done` rises at edge k+1+2^N·HOLD. With N=3, HOLD=4 this is 33 cycles after the start edge.
- Results (`mismatch_cnt`, fail flags, `first_err_vec`) are final when `done` rises.
- Reset asserted mid-sweep aborts immediately to reset values. There is no resumption; a new `start` is required after reset is released.
- A `start` coincident with the DONE entry cycle is ignored, because the FSM is still in DRIVE on that edge.

## Test plan
- N=3, HOLD=4, mode=00, DUT = correct NOR on both outputs, start pulse:
  - `vec` steps 0→7 every 4 cycles; `done` at +33.
  - `mismatch_cnt`=0, `d_fail`=`e_fail`=0.
- Same setup, `dut_e` forced 0:
  - `mismatch_cnt`=1, `first_err_vec`=3'b000.
  - `e_fail`=1, `d_fail`=0.
- Mode=10 (NAND) against a NOR DUT:
  - vectors 1..6 mismatch; `mismatch_cnt`=6, `first_err_vec`=3'b001.
  - `d_fail`=`e_fail`=1.
- Start pulse while busy at vector 3; separately, `rst` pulse at vector 5:
  - first case: sweep continues unaffected.
  - second case: all outputs return to reset values the same cycle; a later start runs a full clean sweep.
- N=4, HOLD=1, mode=11, DUT = AND on both outputs:
  - `vec` advances every cycle; `done` at +17.
  - `mismatch_cnt`=0.
- Back-to-back: after `done`, a second start with a correct DUT:
  - counters and flags are cleared from a previous failing run.
  - final `mismatch_cnt`=0.
